// File: rtl/key_debounce.sv
// Keypad front end: 2-flop synchroniser and an independent debounce FSM per key,
// producing registered one-cycle press pulses, an any-key pulse and held levels.
module key_debounce #(
    parameter int CNT_MAX        = 500_000,
    parameter bit KEY_ACTIVE_LOW = 1'b1
) (
    input  logic       vga_clk,
    input  logic       sys_rst_n,
    input  logic [3:0] key_in,
    output logic       key_up,
    output logic       key_down,
    output logic       key_left,
    output logic       key_right,
    output logic       key_any,
    output logic [3:0] key_level
);

    localparam int            CW           = $clog2(CNT_MAX);
    localparam logic [CW-1:0] CNT_LAST     = CW'(CNT_MAX - 1);
    localparam logic [3:0]    KEY_RELEASED = KEY_ACTIVE_LOW ? 4'hF : 4'h0;

    typedef enum logic [1:0] {
        IDLE,
        PRESS_FILTER,
        HELD,
        RELEASE_FILTER
    } state_t;

    logic [3:0] sync_1;
    logic [3:0] sync_2;
    logic [3:0] p;
    logic [3:0] done;
    logic [3:0] press;

    // Synchronisers reset to the released level so reset itself never looks like a press.
    // NOTE: sequential state is always assigned with <= so every flop samples pre-edge values.
    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            sync_1 <= KEY_RELEASED;
            sync_2 <= KEY_RELEASED;
        end else begin
            sync_1 <= key_in;
            sync_2 <= sync_1;
        end
    end

    assign p = KEY_ACTIVE_LOW ? ~sync_2 : sync_2;

    for (genvar i = 0; i < 4; i++) begin : g_chan
        state_t        state;
        logic [CW-1:0] cnt;
        logic          level_q;

        assign done[i]      = (state == PRESS_FILTER) && p[i] && (cnt == CNT_LAST);
        assign key_level[i] = level_q;

        always_ff @(posedge vga_clk or negedge sys_rst_n) begin
            if (!sys_rst_n) begin
                state   <= IDLE;
                cnt     <= '0;
                level_q <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (p[i]) begin
                            state <= PRESS_FILTER;
                            cnt   <= '0;
                        end
                    end
                    PRESS_FILTER: begin
                        if (!p[i]) begin
                            state <= IDLE;
                            cnt   <= '0;
                        end else if (cnt == CNT_LAST) begin
                            state   <= HELD;
                            cnt     <= '0;
                            level_q <= 1'b1;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    HELD: begin
                        if (!p[i]) begin
                            state <= RELEASE_FILTER;
                            cnt   <= '0;
                        end
                    end
                    RELEASE_FILTER: begin
                        if (p[i]) begin
                            state <= HELD;
                            cnt   <= '0;
                        end else if (cnt == CNT_LAST) begin
                            state   <= IDLE;
                            cnt     <= '0;
                            level_q <= 1'b0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    default: begin
                        state   <= IDLE;
                        cnt     <= '0;
                        level_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Pulses and key_any share one register stage so they always coincide.
    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            press   <= '0;
            key_any <= 1'b0;
        end else begin
            press   <= done;
            key_any <= |done;
        end
    end

    assign key_up    = press[3];
    assign key_down  = press[2];
    assign key_left  = press[1];
    assign key_right = press[0];

endmodule
